stochastic_decoder: RTL and testbench

- Converts a unipolar stochastic bitstream back to a binary value by counting ones over a fixed window of 2^WINDOW_LOG2 clock cycles.
- Sits at the output end of the stochastic datapath, after the mux-based stochastic adders.
- Optional left-shift rescales to undo the 1/2 scaling introduced by mux addition.
- Result is presented with a valid/ready handshake.

---
 rtl/stochastic_pkg.sv | 21 ++
 rtl/stochastic_decoder_if.sv | 22 ++
 rtl/stochastic_ones_counter.sv | 41 ++++
 rtl/stochastic_decoder.sv | 80 ++++++++
 tb/tb_stochastic_decoder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/stochastic_pkg.sv
// Shared types and arithmetic for the stochastic bitstream decoder.
// Holds the FSM state encoding, the default window size and the saturating rescale.
package stochastic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WINDOW_LOG2 = 8;

    // A 32-bit intermediate is wider than RES_W+SCALE_SHIFT for any realistic window,
    // so the shift never loses bits before the clamp to N.
    function automatic int sat_scale(input int ones, input int shift, input int n);
        int scaled;
        scaled = ones << shift;
        return (scaled > n) ? n : scaled;
    endfunction

endpackage

// File: rtl/stochastic_decoder_if.sv
// Control, bitstream and result handshake bundle between the stochastic datapath and the decoder.
interface stochastic_decoder_if #(
    parameter int RES_W = 9
);
    logic             start;
    logic             abort;
    logic             serial_in;
    logic             busy;
    logic [RES_W-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output start, abort, serial_in, result_ready,
        input  busy, result, result_valid
    );

    modport slave (
        input  start, abort, serial_in, result_ready,
        output busy, result, result_valid
    );
endinterface

// File: rtl/stochastic_ones_counter.sv
// Window cycle counter plus ones accumulator; clear wins over enable.
// total_o includes the bit currently presented so the final edge's bit is never lost.
module stochastic_ones_counter #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 bit_i,
    output logic [WINDOW_LOG2:0] total_o,
    output logic                 window_done_o
);
    logic [WINDOW_LOG2-1:0] cyc_q, cyc_d;
    logic [WINDOW_LOG2:0]   ones_q, ones_d;

    assign total_o       = ones_q + (WINDOW_LOG2+1)'(bit_i);
    assign window_done_o = en_i && !clr_i && (cyc_q == '1);

    always_comb begin
        cyc_d  = cyc_q;
        ones_d = ones_q;
        if (clr_i) begin
            cyc_d  = '0;
            ones_d = '0;
        end else if (en_i) begin
            cyc_d  = cyc_q + 1'b1;
            ones_d = total_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q  <= '0;
            ones_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            ones_q <= ones_d;
        end
    end
endmodule

// File: rtl/stochastic_decoder.sv
// Counts ones in a 2^WINDOW_LOG2-cycle window and presents the rescaled, saturated value.
// Result is held in DONE until result_ready; abort cancels COUNT or drops a pending result.
module stochastic_decoder
    import stochastic_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    stochastic_decoder_if.slave  bus
);
    localparam int N     = 1 << WINDOW_LOG2;
    localparam int RES_W = WINDOW_LOG2 + 1;

    state_e           state_q, state_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             cnt_clr, cnt_en, window_done;
    logic [RES_W-1:0] cnt_total;

    stochastic_ones_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_counter (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (cnt_clr),
        .en_i          (cnt_en),
        .bit_i         (bus.serial_in),
        .total_o       (cnt_total),
        .window_done_o (window_done)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_COUNT;
                    cnt_clr = 1'b1;
                end
            end
            ST_COUNT: begin
                // abort beats a completion landing on the same edge
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (window_done) begin
                        state_d  = ST_DONE;
                        result_d = RES_W'(sat_scale(int'(cnt_total), SCALE_SHIFT, N));
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort || bus.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign bus.busy         = (state_q == ST_COUNT);
    assign bus.result_valid = (state_q == ST_DONE);
    assign bus.result       = result_q;
endmodule

// File: tb/tb_stochastic_decoder.sv
// Drives two decoders (SCALE_SHIFT 0 and 1, 16-cycle window) with identical streams;
// expected results are queued at stimulus time and popped by a monitor on each valid rise.
module tb_stochastic_decoder;
    localparam int WL    = 4;
    localparam int NWIN  = 1 << WL;
    localparam int RW    = WL + 1;

    typedef struct {
        int r0;
        int r1;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   last0;
    int   last1;
    logic prev_vld;
    exp_t exp_q[$];

    stochastic_decoder_if #(.RES_W(RW)) bus0 ();
    stochastic_decoder_if #(.RES_W(RW)) bus1 ();

    assign bus1.start        = bus0.start;
    assign bus1.abort        = bus0.abort;
    assign bus1.serial_in    = bus0.serial_in;
    assign bus1.result_ready = bus0.result_ready;

    stochastic_decoder #(.WINDOW_LOG2(WL), .SCALE_SHIFT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    stochastic_decoder #(.WINDOW_LOG2(WL), .SCALE_SHIFT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: ones count scaled by 2^shift, clipped at the window length.
    function automatic int model_result(input int ones, input int shift);
        int v;
        v = ones * (1 << shift);
        return (v > NWIN) ? NWIN : v;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_busy0"},  int'(bus0.busy), 0);
        check({name, "_valid0"}, int'(bus0.result_valid), 0);
        check({name, "_res0"},   int'(bus0.result), 0);
        check({name, "_busy1"},  int'(bus1.busy), 0);
        check({name, "_valid1"}, int'(bus1.result_valid), 0);
        check({name, "_res1"},   int'(bus1.result), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (bus0.result_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_shift0", int'(bus0.result), e.r0);
                    check("result_shift1", int'(bus1.result), e.r1);
                    check("valid_latency", cyc, e.cyc);
                    check("valid_pair", int'(bus1.result_valid), 1);
                end
            end
            prev_vld = bus0.result_valid;
        end
    end

    task automatic run_window(input logic [NWIN-1:0] bits, input int hold, input int start_at,
                              input int abort_at, input int rst_at, input bit rst_in_done);
        int   ones;
        int   e0;
        int   e1;
        ones = $countones(bits);
        e0   = model_result(ones, 0);
        e1   = model_result(ones, 1);
        if (abort_at < 0 && rst_at < 0)
            exp_q.push_back('{r0: e0, r1: e1, cyc: cyc + 1 + NWIN});

        bus0.start     = 1'b1;
        bus0.serial_in = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;

        for (int i = 0; i < NWIN; i++) begin
            bus0.serial_in = bits[i];
            bus0.start     = (i == start_at);
            bus0.abort     = (i == abort_at);
            check("busy_in_window", int'(bus0.busy), 1);
            if (i == rst_at) begin
                #2 rst = 1'b1;
                #1 check_all_zero("rst_mid_count");
                @(posedge clk); #1;
                rst = 1'b0;
                bus0.start = 1'b0;
                last0 = 0;
                last1 = 0;
                return;
            end
            @(posedge clk); #1;
            bus0.start = 1'b0;
            bus0.abort = 1'b0;
            if (i == abort_at) begin
                check("abort_busy", int'(bus0.busy), 0);
                check("abort_valid", int'(bus0.result_valid), 0);
                check("abort_keep0", int'(bus0.result), last0);
                check("abort_keep1", int'(bus1.result), last1);
                repeat (2) @(posedge clk);
                #1 check("abort_no_valid", int'(bus0.result_valid), 0);
                return;
            end
        end

        check("done_busy", int'(bus0.busy), 0);
        check("done_valid", int'(bus0.result_valid), 1);
        last0 = e0;
        last1 = e1;

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", int'(bus0.result_valid), 1);
            check("hold_res0", int'(bus0.result), e0);
            check("hold_res1", int'(bus1.result), e1);
        end

        if (rst_in_done) begin
            #2 rst = 1'b1;
            #1 check_all_zero("rst_in_done");
            @(posedge clk); #1;
            rst = 1'b0;
            last0 = 0;
            last1 = 0;
            return;
        end

        bus0.result_ready = 1'b1;
        bus0.start        = 1'b1;
        @(posedge clk); #1;
        bus0.result_ready = 1'b0;
        bus0.start        = 1'b0;
        check("accept_valid", int'(bus0.result_valid), 0);
        check("accept_busy", int'(bus0.busy), 0);
        @(posedge clk); #1;
        check("start_ignored_done", int'(bus0.busy), 0);
    endtask

    initial begin
        logic [NWIN-1:0] rbits;
        int              ab;
        n_checks = 0;
        n_fail   = 0;
        last0    = 0;
        last1    = 0;
        prev_vld = 1'b0;
        rst               = 1'b1;
        bus0.start        = 1'b0;
        bus0.abort        = 1'b0;
        bus0.serial_in    = 1'b0;
        bus0.result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;

        run_window(16'hFFFF, 0, -1, -1, -1, 1'b0);
        run_window(16'hAAAA, 1, -1, -1, -1, 1'b0);
        run_window(16'h1111, 0, -1, -1, -1, 1'b0);
        run_window(16'h03FF, 0, -1, -1, -1, 1'b0);
        run_window(16'h0F0F, 5, -1, -1, -1, 1'b0);
        run_window(16'h8421, 0,  5, -1, -1, 1'b0);
        run_window(16'hFFF0, 0, -1,  7, -1, 1'b0);
        run_window(16'h5A5A, 0, -1, -1,  6, 1'b0);
        run_window(16'h00FF, 0, -1, -1, -1, 1'b0);
        run_window(16'h0007, 2, -1, -1, -1, 1'b1);
        run_window(16'h0103, 0, -1, -1, -1, 1'b0);

        for (int k = 0; k < 25; k++) begin
            rbits = NWIN'($urandom());
            ab    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NWIN - 1)) : -1;
            run_window(rbits, int'($urandom_range(0, 3)), -1, ab, -1, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
